// File: rtl/board_state_sequencer_pkg.sv
// Shared checkers-board definitions: piece codes, sequencer states, board size.
// Also holds the captured move record and the capture-square midpoint helper.
package board_pkg;

  localparam int BOARD_SIDE = 8;

  localparam logic [7:0] EMPTY      = 8'h00;
  localparam logic [7:0] RED        = 8'h01;
  localparam logic [7:0] BLACK      = 8'h02;
  localparam logic [7:0] RED_KING   = 8'h03;
  localparam logic [7:0] BLACK_KING = 8'h04;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR_SRC,
    WR_CAP,
    WR_DST,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [2:0] src_x;
    logic [2:0] src_y;
    logic [2:0] dst_x;
    logic [2:0] dst_y;
    logic       capture;
    logic [7:0] piece;
  } move_t;

  // Sum kept at 4 bits so (7+7)>>1 lands on 7 rather than wrapping.
  function automatic logic [2:0] midpoint(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[3:1];
  endfunction

endpackage

// File: rtl/board_state_sequencer_if.sv
// Move-command handshake plus state-RAM write port of the board sequencer.
// master = game logic / RAM side, slave = the sequencer.
interface board_state_sequencer_if;

  logic       init_req;
  logic       move_valid;
  logic       move_ready;
  logic [2:0] move_src_x;
  logic [2:0] move_src_y;
  logic [2:0] move_dst_x;
  logic [2:0] move_dst_y;
  logic       move_capture;
  logic [7:0] move_piece;
  logic [7:0] locX_state;
  logic [7:0] locY_state;
  logic [7:0] update_state;
  logic       wea_state_ram;
  logic       busy;
  logic       done;

  modport master (
    output init_req, move_valid, move_src_x, move_src_y, move_dst_x, move_dst_y,
           move_capture, move_piece,
    input  move_ready, locX_state, locY_state, update_state, wea_state_ram, busy, done
  );

  modport slave (
    input  init_req, move_valid, move_src_x, move_src_y, move_dst_x, move_dst_y,
           move_capture, move_piece,
    output move_ready, locX_state, locY_state, update_state, wea_state_ram, busy, done
  );

endinterface

// File: rtl/board_init_pattern.sv
// Combinational opening-layout lookup: square (x, y) -> piece code.
// BLACK fills rows 0-2 and RED rows 5-7, on squares with odd x+y only.
module board_init_pattern
  import board_pkg::*;
(
  input  logic [2:0] x,
  input  logic [2:0] y,
  output logic [7:0] piece
);

  always_comb begin
    piece = EMPTY;
    if (x[0] ^ y[0]) begin
      if (y <= 3'd2)      piece = BLACK;
      else if (y >= 3'd5) piece = RED;
    end
  end

endmodule

// File: rtl/board_state_sequencer.sv
// Sole writer of the icon state RAM: 64-write board init after reset/init_req, then 2-3 writes per move.
// All outputs registered (one cycle behind state); one move at a time, optional KING_PROMOTE_EN promotes on landing.
module board_state_sequencer
  import board_pkg::*;
#(
  parameter int BOARD_N = BOARD_SIDE
) (
  input  logic                    clk,
  input  logic                    reset,
  board_state_sequencer_if.slave  bus
);

  localparam logic [5:0] LAST_SQ = 6'(BOARD_N * BOARD_N - 1);
  localparam logic [2:0] LAST_ROW = 3'(BOARD_N - 1);

  seq_state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  move_t      mv, mv_nxt;
  logic       pending, pending_nxt;
  logic       accept;

  logic [2:0] wr_x_q, wr_y_q, wr_x_nxt, wr_y_nxt;
  logic [7:0] wr_dat_q, wr_dat_nxt;
  logic       wea_q, wea_nxt;
  logic       done_q, done_nxt;
  logic       busy_q;
  logic       ready_q, ready_nxt;

  logic [7:0] init_piece;
  logic [7:0] dst_piece;
  logic [2:0] cap_x, cap_y;

  board_init_pattern u_init_pattern (
    .x     (cnt[2:0]),
    .y     (cnt[5:3]),
    .piece (init_piece)
  );

  assign cap_x = midpoint(mv.src_x, mv.dst_x);
  assign cap_y = midpoint(mv.src_y, mv.dst_y);

`ifdef KING_PROMOTE_EN
  always_comb begin
    dst_piece = mv.piece;
    if (mv.piece == RED && mv.dst_y == 3'd0)
      dst_piece = RED_KING;
    else if (mv.piece == BLACK && mv.dst_y == LAST_ROW)
      dst_piece = BLACK_KING;
  end
`else
  assign dst_piece = mv.piece;
`endif

  // init_req wins over a move offered in the same cycle, even though ready is already up.
  assign accept = bus.move_valid && ready_q && !bus.init_req;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mv_nxt      = mv;
    pending_nxt = pending || (bus.init_req && state != IDLE);
    wea_nxt     = 1'b0;
    done_nxt    = 1'b0;
    wr_x_nxt    = wr_x_q;
    wr_y_nxt    = wr_y_q;
    wr_dat_nxt  = wr_dat_q;

    case (state)
      INIT: begin
        wea_nxt    = 1'b1;
        wr_x_nxt   = cnt[2:0];
        wr_y_nxt   = cnt[5:3];
        wr_dat_nxt = init_piece;
        cnt_nxt    = cnt + 6'd1;
        if (cnt == LAST_SQ) state_nxt = DONE;
      end
      IDLE: begin
        if (bus.init_req || pending) begin
          state_nxt   = INIT;
          cnt_nxt     = '0;
          pending_nxt = 1'b0;
        end else if (accept) begin
          state_nxt = WR_SRC;
          mv_nxt    = '{src_x:   bus.move_src_x,
                        src_y:   bus.move_src_y,
                        dst_x:   bus.move_dst_x,
                        dst_y:   bus.move_dst_y,
                        capture: bus.move_capture,
                        piece:   bus.move_piece};
        end
      end
      WR_SRC: begin
        wea_nxt    = 1'b1;
        wr_x_nxt   = mv.src_x;
        wr_y_nxt   = mv.src_y;
        wr_dat_nxt = EMPTY;
        state_nxt  = mv.capture ? WR_CAP : WR_DST;
      end
      WR_CAP: begin
        wea_nxt    = 1'b1;
        wr_x_nxt   = cap_x;
        wr_y_nxt   = cap_y;
        wr_dat_nxt = EMPTY;
        state_nxt  = WR_DST;
      end
      WR_DST: begin
        wea_nxt    = 1'b1;
        wr_x_nxt   = mv.dst_x;
        wr_y_nxt   = mv.dst_y;
        wr_dat_nxt = dst_piece;
        state_nxt  = DONE;
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase

    ready_nxt = (state == IDLE) && !accept && !bus.init_req && !pending;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      cnt      <= '0;
      mv       <= '0;
      pending  <= 1'b0;
      wr_x_q   <= '0;
      wr_y_q   <= '0;
      wr_dat_q <= '0;
      wea_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mv       <= mv_nxt;
      pending  <= pending_nxt;
      wr_x_q   <= wr_x_nxt;
      wr_y_q   <= wr_y_nxt;
      wr_dat_q <= wr_dat_nxt;
      wea_q    <= wea_nxt;
      done_q   <= done_nxt;
      busy_q   <= (state_nxt != IDLE);
      ready_q  <= ready_nxt;
    end
  end

  assign bus.locX_state    = {5'b0, wr_x_q};
  assign bus.locY_state    = {5'b0, wr_y_q};
  assign bus.update_state  = wr_dat_q;
  assign bus.wea_state_ram = wea_q;
  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.move_ready    = ready_q;

endmodule

// File: tb/tb_board_state_sequencer.sv
// Bench for board_state_sequencer: RAM writes are scored in order against a queue of expected writes,
// move vectors come from a table, init/reset corner cases are hand-written sequences.
module tb_board_state_sequencer;
  import board_pkg::*;

`ifdef KING_PROMOTE_EN
  localparam bit PROMO = 1'b1;
`else
  localparam bit PROMO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  board_state_sequencer_if bus ();

  board_state_sequencer #(.BOARD_N(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [2:0] ref_x, ref_y;
  logic [7:0] ref_piece;
  board_init_pattern ref_pattern (.x(ref_x), .y(ref_y), .piece(ref_piece));

  typedef struct {
    logic [2:0] sx, sy, dx, dy;
    logic       cap;
    logic [7:0] piece;
    logic [2:0] mx, my;
    logic [7:0] exp_dst;
    int         done_at;
  } vec_t;

  vec_t        vecs[7];
  logic [7:0]  ref_tab[64];
  logic [7:0]  board[64];
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  int          errors = 0;
  int          checks = 0;

  function automatic int idx(input int x, input int y);
    return y * 8 + x;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Scoreboard: every presented write must be the next expected one.
  always @(negedge clk) begin
    if (bus.wea_state_ram === 1'b1) begin
      board[{bus.locY_state[2:0], bus.locX_state[2:0]}] = bus.update_state;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x=%0d y=%0d d=%02h required no write",
                 bus.locX_state, bus.locY_state, bus.update_state);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.locX_state, bus.locY_state, bus.update_state} !== mon_e) begin
          errors++;
          $display("FAIL write: got x=%0d y=%0d d=%02h required x=%0d y=%0d d=%02h",
                   bus.locX_state, bus.locY_state, bus.update_state,
                   mon_e[23:16], mon_e[15:8], mon_e[7:0]);
        end
      end
    end
  end

  task automatic push_wr(input logic [2:0] x, input logic [2:0] y, input logic [7:0] d);
    exp_q.push_back({5'b0, x, 5'b0, y, d});
  endtask

  task automatic push_init();
    for (int i = 0; i < 64; i++) push_wr(3'(i % 8), 3'(i / 8), ref_tab[i]);
  endtask

  // Called at the negedge where reset was released (cycle 0).
  task automatic run_init(input string nm);
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      if (c == 1)  check({nm, "_wea_c1"}, bus.wea_state_ram, 1);
      if (c == 65) check({nm, "_wea_c65"}, bus.wea_state_ram, 0);
      if (c >= 64) check({nm, "_done"}, bus.done, (c == 65));
      if (c >= 65) check({nm, "_ready"}, bus.move_ready, (c == 66));
    end
    check({nm, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.move_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.move_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout: got ready=%b required 1 within 200 cycles", nm, bus.move_ready);
    end
  endtask

  task automatic drive_move(input logic [2:0] sx, input logic [2:0] sy, input logic [2:0] dx,
                            input logic [2:0] dy, input logic cap, input logic [7:0] piece);
    bus.move_src_x   = sx;
    bus.move_src_y   = sy;
    bus.move_dst_x   = dx;
    bus.move_dst_y   = dy;
    bus.move_capture = cap;
    bus.move_piece   = piece;
    bus.move_valid   = 1'b1;
  endtask

  task automatic scramble_move();
    bus.move_src_x   = 3'($urandom);
    bus.move_src_y   = 3'($urandom);
    bus.move_dst_x   = 3'($urandom);
    bus.move_dst_y   = 3'($urandom);
    bus.move_capture = 1'($urandom);
    bus.move_piece   = 8'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.init_req   = 1'b0;
    bus.move_valid = 1'b0;
    drive_move(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    bus.move_valid = 1'b0;

    //                sx  sy  dx  dy  cap  piece   mx  my  exp_dst                      done_at
    vecs[0] = '{3'd2, 3'd5, 3'd3, 3'd4, 1'b0, 8'h01, 3'd0, 3'd0, 8'h01,                  3};
    vecs[1] = '{3'd2, 3'd5, 3'd4, 3'd3, 1'b1, 8'h01, 3'd3, 3'd4, 8'h01,                  4};
    vecs[2] = '{3'd1, 3'd1, 3'd0, 3'd0, 1'b0, 8'h01, 3'd0, 3'd0, PROMO ? 8'h03 : 8'h01, 3};
    vecs[3] = '{3'd1, 3'd5, 3'd3, 3'd7, 1'b1, 8'h02, 3'd2, 3'd6, PROMO ? 8'h04 : 8'h02, 4};
    vecs[4] = '{3'd5, 3'd2, 3'd7, 3'd0, 1'b1, 8'h03, 3'd6, 3'd1, 8'h03,                  4};
    vecs[5] = '{3'd7, 3'd7, 3'd5, 3'd5, 1'b1, 8'hAA, 3'd6, 3'd6, 8'hAA,                  4};
    vecs[6] = '{3'd0, 3'd0, 3'd7, 3'd7, 1'b1, 8'h02, 3'd3, 3'd3, PROMO ? 8'h04 : 8'h02, 4};

    for (int i = 0; i < 64; i++) begin
      ref_x = 3'(i % 8);
      ref_y = 3'(i / 8);
      #1;
      ref_tab[i] = ref_piece;
    end

    repeat (3) @(negedge clk);
    check("rst_wea",   bus.wea_state_ram, 0);
    check("rst_locx",  bus.locX_state, 0);
    check("rst_locy",  bus.locY_state, 0);
    check("rst_data",  bus.update_state, 0);
    check("rst_done",  bus.done, 0);
    check("rst_busy",  bus.busy, 1);
    check("rst_ready", bus.move_ready, 0);

    // Opening fill after reset release.
    push_init();
    reset = 1'b0;
    run_init("init");
    check("board_1_0", board[idx(1, 0)], 8'h02);
    check("board_0_0", board[idx(0, 0)], 8'h00);
    check("board_0_5", board[idx(0, 5)], 8'h01);
    check("board_3_3", board[idx(3, 3)], 8'h00);
    check("busy_idle", bus.busy, 0);

    // Table-driven moves.
    for (int i = 0; i < 7; i++) begin
      wait_ready($sformatf("vec%0d", i));
      drive_move(vecs[i].sx, vecs[i].sy, vecs[i].dx, vecs[i].dy, vecs[i].cap, vecs[i].piece);
      push_wr(vecs[i].sx, vecs[i].sy, 8'h00);
      if (vecs[i].cap) push_wr(vecs[i].mx, vecs[i].my, 8'h00);
      push_wr(vecs[i].dx, vecs[i].dy, vecs[i].exp_dst);
      @(posedge clk);
      #1;
      bus.move_valid = 1'b0;
      scramble_move();
      @(negedge clk);
      check($sformatf("vec%0d_ready_drop", i), bus.move_ready, 0);
      check($sformatf("vec%0d_busy", i), bus.busy, 1);
      for (int c = 1; c <= vecs[i].done_at + 1; c++) begin
        @(negedge clk);
        check($sformatf("vec%0d_done_c%0d", i, c), bus.done, (c == vecs[i].done_at));
        check($sformatf("vec%0d_ready_c%0d", i, c), bus.move_ready, (c == vecs[i].done_at + 1));
      end
      check($sformatf("vec%0d_writes_left", i), exp_q.size(), 0);
    end

    // init_req during WR_SRC: move finishes, then a full init; held move_valid is ignored meanwhile.
    wait_ready("initreq");
    drive_move(3'd2, 3'd5, 3'd3, 3'd4, 1'b0, 8'h01);
    push_wr(3'd2, 3'd5, 8'h00);
    push_wr(3'd3, 3'd4, 8'h01);
    push_init();
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.init_req = 1'b1;
    @(posedge clk);
    #1;
    bus.init_req = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      check($sformatf("initreq_done_c%0d", c), bus.done, (c == 3 || c == 69));
      check($sformatf("initreq_ready_c%0d", c), bus.move_ready, (c == 70));
    end
    bus.move_valid = 1'b0;
    check("initreq_writes_left", exp_q.size(), 0);

    // Reset while the captured square is being written.
    wait_ready("rstcap");
    drive_move(3'd2, 3'd5, 3'd4, 3'd3, 1'b1, 8'h01);
    push_wr(3'd2, 3'd5, 8'h00);
    @(posedge clk);
    #1;
    bus.move_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rstcap_wea_before", bus.wea_state_ram, 1);
    check("rstcap_locx_before", bus.locX_state, 3);
    check("rstcap_locy_before", bus.locY_state, 4);
    reset = 1'b1;
    #1;
    check("rstcap_wea_async", bus.wea_state_ram, 0);
    check("rstcap_busy", bus.busy, 1);
    check("rstcap_ready", bus.move_ready, 0);
    repeat (2) @(negedge clk);
    push_init();
    reset = 1'b0;
    run_init("reinit");

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
